spu_fetch_buffer: RTL and testbench
===================================

// Module: spu_fetch_buffer
// PURPOSE
//  Dual-issue instruction fetch front end with a prefetch buffer.
//  - Reads one aligned 64-bit instruction pair per request from the synchronous local-store instruction RAM.
//  - Queues each pair with its PC, then presents pairs to IF/ID (even/odd decode) under a valid/ready handshake.
//  - Absorbs decode stalls (nop) and services branch redirects by flushing all queued and in-flight fetches.
// PARAMETERS
//  DEPTH     4   buffer entries (instruction pairs); power of 2, >=2
//  ADDR_W    18  local-store byte-address width (256 KB)
//  PC_RESET  0   byte address fetched first after reset; bits[2:0] must be 0
// PORTS
//  clk             in   1        clock
//  reset           in   1        synchronous, active-high reset
//  imem_req        out  1        read request this cycle
//  imem_addr       out  ADDR_W   byte address of pair; bits[2:0] always 0
//  imem_rdata      in   64       pair read; valid the cycle after imem_req; [63:32]=lower address
//  redirect_valid  in   1        branch/flush redirect this cycle
//  redirect_pc     in   ADDR_W   redirect target byte address; word aligned
//  out_valid       out  1        head pair available
//  out_ready       in   1        decode accepts head (low when decode issues nop/stall)
//  out_instr1      out  32       first (even-address) instruction
//  out_instr2      out  32       second instruction
//  out_mask        out  2        [1]=instr1 valid, [0]=instr2 valid
//  out_pc          out  ADDR_W   byte address of out_instr1
// BEHAVIOUR
//  - Reset: fetch_pc=PC_RESET, buffer empty, in-flight cleared, out_valid=0, imem_req=0, counters=0.
//    When empty: out_instr1/2=0, out_mask=00, out_pc=0.
//  - Request: imem_req = !reset & !redirect_valid & (count+inflight < DEPTH).
//    - No credit is taken for a same-cycle pop.
//    - imem_addr=fetch_pc.
//    - On request, fetch_pc += 8, wrapping mod 2**ADDR_W.
//  - Response: the cycle after a request, imem_rdata is pushed with its PC and mask.
//    - Dropped if squashed by a redirect asserted in its request or response cycle.
//  - Mask: 2'b11 normally. 2'b01 for the first pair after a redirect with redirect_pc[2]=1.
//  - Pop: on out_valid & out_ready; head advances. Push and pop in the same cycle leave count unchanged.
//  - Latency: reset deasserted in cycle C0 -> request in C0, push at end of C1, out_valid=1 in C2.
//    Sustained throughput is 1 pair/cycle while out_ready=1.
//  - Redirect (highest priority) at the clock edge:
//    - Buffer emptied; in-flight squashed; same-cycle pop and push ignored.
//    - fetch_pc = {redirect_pc[ADDR_W-1:3],3'b000}.
//    - out_valid=0 the next cycle; new request that cycle; first new pair visible 2 cycles after the edge.
//  - Full: count==DEPTH -> no request; out_valid stays 1; no entry is ever overwritten.
//  - Back-to-back redirects: the last one wins; each restarts the 2-cycle refill.
//  - Reset mid-operation overrides redirect and all traffic; the state above is restored in one edge.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds 32-bit outputs perf_stall_cnt and perf_redirect_cnt.
//    - perf_stall_cnt: +1 per cycle with out_valid & !out_ready.
//    - perf_redirect_cnt: +1 per redirect edge.
//    - Both saturate at 0xFFFFFFFF; cleared by reset.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; datapath and timing identical.
// TESTING
//  - Reset, out_ready=1, RAM word n = n.
//    -> imem_addr 0,8,16,...; out_valid from cycle 2.
//    -> pairs (0,1),(2,3),... with out_pc 0,8,16; mask 11.
//  - out_ready=0 for 10 cycles.
//    -> count reaches 4; imem_req low; no pair lost or duplicated.
//    -> out_ready=1 drains in order, PCs consecutive.
//  - redirect_pc=0x104 mid-stream.
//    -> next out pair has out_pc=0x100, mask=01, instr2=word 0x104.
//    -> no stale pair after the redirect edge.
//  - Redirect in the same cycle as pop and response.
//    -> buffer empty the next cycle; out_valid=0 for exactly 2 cycles.
//  - PC_RESET=0x3FFF8.
//    -> addresses 0x3FFF8 then 0x00000; out_pc wraps likewise.
//  - FETCH_PERF_CNT_EN: 7 stall cycles and 3 redirects.
//    -> perf_stall_cnt=7, perf_redirect_cnt=3; both 0 after reset.

Source files
------------

// File: rtl/spu_fetch_buffer.sv
// Dual-issue instruction fetch front end: fetches aligned 64-bit pairs, queues them with PC/mask,
// and hands them to decode under valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module spu_fetch_buffer #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 18,
    parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [63:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr1,
    output logic [31:0]       out_instr2,
    output logic [1:0]        out_mask,
    output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              odd_start_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [1:0]        inflight_mask_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic [63:0]       instr_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
    logic [1:0]        mask_mem_r  [DEPTH];

    logic [CNT_W:0]    occupancy_s;
    logic              req_s;
    logic              push_s;
    logic              pop_s;
    logic              not_empty_s;
    logic              unused_redirect_bits_s;

    // Credit check counts queued plus in-flight pairs; a same-cycle pop frees nothing.
    always_comb begin
        occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
        not_empty_s = (count_r != CNT_W'(0));
        req_s       = !reset && !redirect_valid && (occupancy_s < DEPTH_OCC);
        push_s      = inflight_r && !redirect_valid && !reset;
        pop_s       = not_empty_s && out_ready && !redirect_valid && !reset;
        imem_req    = req_s;
        imem_addr   = fetch_pc_r;
        unused_redirect_bits_s = ^redirect_pc[1:0];
    end

    // Head entry presentation; outputs read as zero while the buffer is empty.
    always_comb begin
        out_valid  = 1'b0;
        out_instr1 = 32'h0000_0000;
        out_instr2 = 32'h0000_0000;
        out_mask   = 2'b00;
        out_pc     = {ADDR_W{1'b0}};
        if (not_empty_s) begin
            out_valid  = 1'b1;
            out_instr1 = instr_mem_r[head_r][63:32];
            out_instr2 = instr_mem_r[head_r][31:0];
            out_mask   = mask_mem_r[head_r];
            out_pc     = pc_mem_r[head_r];
        end else begin
            out_valid  = 1'b0;
        end
    end

    // Fetch PC, in-flight tracking and queue pointers; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r      <= PC_RESET;
            odd_start_r     <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_pc_r   <= {ADDR_W{1'b0}};
            inflight_mask_r <= 2'b00;
            head_r          <= PTR_W'(0);
            tail_r          <= PTR_W'(0);
            count_r         <= CNT_W'(0);
        end else if (redirect_valid) begin
            fetch_pc_r  <= {redirect_pc[ADDR_W-1:3], 3'b000};
            odd_start_r <= redirect_pc[2];
            inflight_r  <= 1'b0;
            head_r      <= PTR_W'(0);
            tail_r      <= PTR_W'(0);
            count_r     <= CNT_W'(0);
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                fetch_pc_r      <= fetch_pc_r + ADDR_W'(8);
                odd_start_r     <= 1'b0;
                inflight_pc_r   <= fetch_pc_r;
                inflight_mask_r <= odd_start_r ? 2'b01 : 2'b11;
            end
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[tail_r] <= imem_rdata;
            pc_mem_r[tail_r]    <= inflight_pc_r;
            mask_mem_r[tail_r]  <= inflight_mask_r;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating stall and redirect event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt    <= 32'h0000_0000;
            perf_redirect_cnt <= 32'h0000_0000;
        end else begin
            if (not_empty_s && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spu_fetch_buffer.sv
// Scoreboard bench for spu_fetch_buffer: directed streams, stalls, redirects and PC wrap.
module tb_spu_fetch_buffer;

    localparam int AW = 18;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [1:0]    mask;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [63:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr1;
    logic [31:0]   out_instr2;
    logic [1:0]    out_mask;
    logic [AW-1:0] out_pc;

    logic          p2_req;
    logic [AW-1:0] p2_addr;
    logic [63:0]   p2_rdata;
    logic          p2_redirect;
    logic [AW-1:0] p2_redirect_pc;
    logic          p2_ready;
    logic          p2_unused_valid;
    logic [31:0]   p2_unused_i1;
    logic [31:0]   p2_unused_i2;
    logic [1:0]    p2_unused_mask;
    logic [AW-1:0] p2_unused_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_redirect_cnt;
    logic [31:0]   p2_unused_stall;
    logic [31:0]   p2_unused_redir;
`endif

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [31:0]   mon_w;
    int            checks = 0;
    int            errors = 0;
    int            reqs;
    logic [15:0]   pat;

    spu_fetch_buffer #(.DEPTH(4), .ADDR_W(AW), .PC_RESET(18'h00000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr1(out_instr1),
        .out_instr2(out_instr2), .out_mask(out_mask), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    spu_fetch_buffer #(.DEPTH(4), .ADDR_W(AW), .PC_RESET(18'h3FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(p2_req), .imem_addr(p2_addr),
        .imem_rdata(p2_rdata), .redirect_valid(p2_redirect), .redirect_pc(p2_redirect_pc),
        .out_valid(p2_unused_valid), .out_ready(p2_ready), .out_instr1(p2_unused_i1),
        .out_instr2(p2_unused_i2), .out_mask(p2_unused_mask), .out_pc(p2_unused_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(p2_unused_stall), .perf_redirect_cnt(p2_unused_redir)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAM model: word n holds value n, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= {(32'(imem_addr) >> 2), (32'(imem_addr) >> 2) + 32'd1};
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_stream(input logic [AW-1:0] start, input logic [1:0] m0);
        exp_t          e;
        logic [AW-1:0] pc;
        sb_q.delete();
        pc = start;
        for (int i = 0; i < 128; i++) begin
            e.pc   = pc;
            e.mask = (i == 0) ? m0 : 2'b11;
            sb_q.push_back(e);
            pc = pc + 18'd8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted pair; checks zeroed outputs when empty.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (out_ready && !redirect_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got pc 0x%0h expected no pair", out_pc);
                    end else begin
                        mon_e = sb_q.pop_front();
                        mon_w = 32'(mon_e.pc) >> 2;
                        check("pair", {out_pc, out_mask, out_instr2, (out_mask[1] ? out_instr1 : 32'h0)},
                              {mon_e.pc, mon_e.mask, mon_w + 32'd1, (mon_e.mask[1] ? mon_w : 32'h0)});
                    end
                end
            end else begin
                check("empty_outputs", {out_pc, out_mask, out_instr1, out_instr2}, 128'h0);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 18'h0;
        out_ready      = 1'b1;
        p2_rdata       = 64'h0;
        p2_redirect    = 1'b0;
        p2_redirect_pc = 18'h0;
        p2_ready       = 1'b1;
        imem_rdata     = 64'h0;
        repeat (3) tick();
        check("reset_state", {out_valid, imem_req, out_mask, out_pc, out_instr1, out_instr2}, 128'h0);

        // Start-up latency and plain streaming.
        reset = 1'b0;
        start_stream(18'h0, 2'b11);
        #1;
        check("c0_req", {imem_req, imem_addr}, {1'b1, 18'h0});
        check("wrap_c0_req", {p2_req, p2_addr}, {1'b1, 18'h3FFF8});
        tick();
        check("c1_no_valid", out_valid, 1'b0);
        check("c1_addr", imem_addr, 18'h8);
        check("wrap_c1_addr", {p2_req, p2_addr}, {1'b1, 18'h0});
        tick();
        check("c2_valid", {out_valid, out_pc}, {1'b1, 18'h0});
        repeat (20) tick();

        // Reset mid-stream, then decode stalled from the start: fills to DEPTH and stops.
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        check("rst_mid", {out_valid, imem_req, out_pc}, 128'h0);
        tick();
        reset = 1'b0;
        start_stream(18'h0, 2'b11);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (imem_req) reqs++;
            @(posedge clk);
            #1;
        end
        check("stall_req_count", 32'(reqs), 32'd4);
        #2;
        check("full_no_req", {imem_req, out_valid}, {1'b0, 1'b1});
        out_ready = 1'b1;
        repeat (20) tick();

        // Redirect to an odd word while streaming (pop and response in the same cycle).
        redirect_valid = 1'b1;
        redirect_pc    = 18'h104;
        start_stream(18'h100, 2'b01);
        tick();
        redirect_valid = 1'b0;
        check("rd_gap1", out_valid, 1'b0);
        tick();
        check("rd_gap2", out_valid, 1'b0);
        tick();
        check("rd_first", {out_valid, out_pc, out_mask}, {1'b1, 18'h100, 2'b01});
        repeat (10) tick();

        // Back-to-back redirects: last one wins, stream wraps through address 0.
        redirect_valid = 1'b1;
        redirect_pc    = 18'h200;
        start_stream(18'h200, 2'b11);
        tick();
        redirect_pc = 18'h3FFF8;
        start_stream(18'h3FFF8, 2'b11);
        tick();
        redirect_valid = 1'b0;
        check("b2b_gap1", out_valid, 1'b0);
        tick();
        check("b2b_gap2", out_valid, 1'b0);
        tick();
        check("b2b_first", {out_valid, out_pc, out_mask}, {1'b1, 18'h3FFF8, 2'b11});
        repeat (10) tick();

        // Irregular decode stalls.
        pat = 16'hB2E5;
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();

        // Redirect while the buffer is full and decode is stalled.
        out_ready = 1'b0;
        repeat (8) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 18'h1000;
        start_stream(18'h1000, 2'b11);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("full_rd_gap1", out_valid, 1'b0);
        tick();
        check("full_rd_gap2", out_valid, 1'b0);
        tick();
        check("full_rd_first", {out_valid, out_pc}, {1'b1, 18'h1000});
        repeat (10) tick();

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1;
        tick();
        tick();
        check("perf_rst", {perf_stall_cnt, perf_redirect_cnt}, 128'h0);
        reset = 1'b0;
        start_stream(18'h0, 2'b11);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (7) tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            redirect_valid = 1'b1;
            redirect_pc    = 18'(32'h40 * (k + 1));
            start_stream(18'(32'h40 * (k + 1)), 2'b11);
            tick();
            redirect_valid = 1'b0;
            repeat (4) tick();
        end
        check("perf_stall", perf_stall_cnt, 32'd7);
        check("perf_redirect", perf_redirect_cnt, 32'd3);
`endif

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
